// File: rtl/int_nest_ctrl_pkg.sv
// Shared types and defaults for the nested interrupt controller.
package int_nest_ctrl_pkg;

    // Request FSM: IDLE arbitrates, REQ holds a request until acked or disabled
    typedef enum logic [0:0] {
        INT_ST_IDLE = 1'b0,
        INT_ST_REQ  = 1'b1
    } int_state_e;

    // Default handler base and per-source vector spacing
    localparam logic [31:0] INT_VEC_BASE_DEF   = 32'h0000_4000;
    localparam logic [31:0] INT_VEC_STRIDE_DEF = 32'h0000_0100;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: highest set index wins.
module int_prio_enc #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan upward so the last (highest) set bit is the one kept
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_nest_ctrl.sv
// Nested, fixed-priority interrupt controller with an EPC stack.
// Build option: define INT_VECTOR_EN for per-source vectored handlers
// (vector_pc = VEC_BASE + int_src*VEC_STRIDE); otherwise every source uses VEC_BASE.
module int_nest_ctrl
    import int_nest_ctrl_pkg::*;
#(
    parameter int unsigned          NUM_SRC    = 3,
    parameter int unsigned          NEST_DEPTH = 3,
    parameter int unsigned          PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]  VEC_BASE   = PC_WIDTH'(INT_VEC_BASE_DEF),
    parameter logic [PC_WIDTH-1:0]  VEC_STRIDE = PC_WIDTH'(INT_VEC_STRIDE_DEF)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                irq,
    input  logic                              ie_wr_en,
    input  logic                              ie_wr_data,
    output logic                              ie,
    output logic                              int_req,
    output logic [$clog2(NUM_SRC)-1:0]        int_src,
    output logic [PC_WIDTH-1:0]               vector_pc,
    input  logic                              int_ack,
    input  logic [PC_WIDTH-1:0]               epc_in,
    input  logic                              eret,
    output logic [PC_WIDTH-1:0]               epc_out,
    output logic [$clog2(NEST_DEPTH+1)-1:0]   depth,
    output logic [NUM_SRC-1:0]                pending,
    output logic [NUM_SRC-1:0]                in_service,
    output logic                              eret_err
);

    localparam int unsigned SRC_W   = $clog2(NUM_SRC);
    localparam int unsigned DEPTH_W = $clog2(NEST_DEPTH + 1);
    localparam int unsigned STK_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

`ifdef INT_VECTOR_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    int_state_e          state;
    int_state_e          state_nxt;
    logic [NUM_SRC-1:0]  irq_q;
    logic [NUM_SRC-1:0]  irq_rise;
    logic [NUM_SRC-1:0]  above_svc;
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  ack_clr;
    logic [NUM_SRC-1:0]  svc_nxt;
    logic                elig_any;
    logic [SRC_W-1:0]    elig_idx;
    logic                svc_any;
    logic [SRC_W-1:0]    svc_idx;
    logic                ie_nxt;
    logic                ack_fire;
    logic                int_req_nxt;
    logic [SRC_W-1:0]    int_src_nxt;
    logic [PC_WIDTH-1:0] vector_nxt;
    logic                pop;
    logic [DEPTH_W-1:0]  depth_pop;
    logic [DEPTH_W-1:0]  depth_nxt;
    logic [PC_WIDTH-1:0] top_after_pop;
    logic [PC_WIDTH-1:0] epc_nxt;
    logic [PC_WIDTH-1:0] stack [NEST_DEPTH];

    // Highest eligible pending source
    int_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(SRC_W)) u_elig_enc (
        .req   (eligible),
        .valid (elig_any),
        .idx   (elig_idx)
    );

    // Highest source currently in service (top of the nesting chain)
    int_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(SRC_W)) u_svc_enc (
        .req   (in_service),
        .valid (svc_any),
        .idx   (svc_idx)
    );

    // Edge detect, IE next value and eligibility mask
    always_comb begin
        irq_rise  = irq & ~irq_q;
        ie_nxt    = ie_wr_en ? ie_wr_data : ie;
        above_svc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            above_svc[i] = !svc_any || (i > int'(svc_idx));
        end
        eligible = pending & above_svc
                 & {NUM_SRC{ie && (depth < DEPTH_W'(NEST_DEPTH))}};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INT_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and request outputs; int_src is frozen while in REQ
    always_comb begin
        state_nxt   = state;
        int_req_nxt = int_req;
        int_src_nxt = int_src;
        ack_fire    = 1'b0;
        case (state)
            INT_ST_IDLE: begin
                if (elig_any) begin
                    state_nxt   = INT_ST_REQ;
                    int_req_nxt = 1'b1;
                    int_src_nxt = elig_idx;
                end
            end
            INT_ST_REQ: begin
                if (int_ack) begin
                    ack_fire    = 1'b1;
                    state_nxt   = INT_ST_IDLE;
                    int_req_nxt = 1'b0;
                end else if (!ie_nxt) begin
                    state_nxt   = INT_ST_IDLE;
                    int_req_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = INT_ST_IDLE;
                int_req_nxt = 1'b0;
            end
        endcase
        vector_nxt = VEC_EN ? (VEC_BASE + PC_WIDTH'(int_src_nxt) * VEC_STRIDE) : VEC_BASE;
    end

    // Stack, service and pending updates: pop happens before push
    always_comb begin
        pop           = eret && (depth != '0);
        depth_pop     = depth - DEPTH_W'(pop);
        top_after_pop = '0;
        if (depth_pop != '0) begin
            top_after_pop = stack[STK_W'(depth_pop - DEPTH_W'(1))];
        end
        svc_nxt = in_service;
        ack_clr = '0;
        if (pop) begin
            svc_nxt[svc_idx] = 1'b0;
        end
        if (ack_fire) begin
            svc_nxt[int_src] = 1'b1;
            ack_clr[int_src] = 1'b1;
        end
        depth_nxt = ack_fire ? (depth_pop + DEPTH_W'(1)) : depth_pop;
        epc_nxt   = ack_fire ? epc_in : top_after_pop;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            depth      <= '0;
            ie         <= 1'b1;
            int_req    <= 1'b0;
            int_src    <= '0;
            vector_pc  <= VEC_BASE;
            eret_err   <= 1'b0;
            epc_out    <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            irq_q      <= irq;
            ie         <= ie_nxt;
            int_req    <= int_req_nxt;
            int_src    <= int_src_nxt;
            vector_pc  <= vector_nxt;
            eret_err   <= eret && (depth == '0);
            pending    <= (pending & ~ack_clr) | irq_rise;
            in_service <= svc_nxt;
            depth      <= depth_nxt;
            epc_out    <= epc_nxt;
            if (ack_fire) begin
                stack[STK_W'(depth_pop)] <= epc_in;
            end
        end
    end

endmodule

// File: tb/tb_int_nest_ctrl.sv
// Scoreboard bench for int_nest_ctrl: directed scenarios followed by random traffic.
module tb_int_nest_ctrl;

    localparam int unsigned NSRC  = 4;
    localparam int unsigned NDEP  = 3;
    localparam logic [31:0] VBASE = 32'h0000_4000;
    localparam logic [31:0] VSTR  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        ie_wr_en, ie_wr_data, ie;
    logic        int_req;
    logic [1:0]  int_src;
    logic [31:0] vector_pc;
    logic        int_ack;
    logic [31:0] epc_in;
    logic        eret;
    logic [31:0] epc_out;
    logic [1:0]  depth;
    logic [3:0]  pending, in_service;
    logic        eret_err;

    always #5 clk = ~clk;

    int_nest_ctrl #(
        .NUM_SRC(NSRC), .NEST_DEPTH(NDEP), .PC_WIDTH(32),
        .VEC_BASE(VBASE), .VEC_STRIDE(VSTR)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq),
        .ie_wr_en(ie_wr_en), .ie_wr_data(ie_wr_data), .ie(ie),
        .int_req(int_req), .int_src(int_src), .vector_pc(vector_pc),
        .int_ack(int_ack), .epc_in(epc_in), .eret(eret),
        .epc_out(epc_out), .depth(depth), .pending(pending),
        .in_service(in_service), .eret_err(eret_err)
    );

    typedef struct {
        bit          req;
        int          src;
        logic [31:0] vec;
        bit          ie;
        int          dep;
        logic [31:0] epc;
        bit [3:0]    pend;
        bit [3:0]    svc;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Reference model: pending set, IE, outstanding request and a stack of (epc, source)
    bit [3:0]    m_prev, m_pend;
    bit          m_ie, m_req, m_err;
    int          m_src;
    logic [31:0] m_epc[$];
    int          m_ssrc[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] vec_of(input int s);
`ifdef INT_VECTOR_EN
        return VBASE + 32'(s) * VSTR;
`else
        return VBASE + 32'(s - s);
`endif
    endfunction

    task automatic model_step(input bit r, input bit [3:0] irq_v, input bit ack_v,
                              input logic [31:0] epc_v, input bit eret_v,
                              input bit we, input bit wd);
        bit [3:0] rise;
        bit       new_ie, ack_hit;
        int       top, best, acked;
        if (r) begin
            m_prev = '0; m_pend = '0; m_ie = 1'b1; m_req = 1'b0; m_src = 0; m_err = 1'b0;
            m_epc.delete(); m_ssrc.delete();
            return;
        end
        rise    = irq_v & ~m_prev;
        new_ie  = we ? wd : m_ie;
        ack_hit = m_req && ack_v;
        acked   = m_src;
        m_err   = eret_v && (m_epc.size() == 0);
        top = -1;
        foreach (m_ssrc[k]) if (m_ssrc[k] > top) top = m_ssrc[k];
        best = -1;
        if (m_ie && m_epc.size() < NDEP) begin
            for (int i = 0; i < NSRC; i++) if (m_pend[i] && i > top) best = i;
        end
        if (!m_req) begin
            if (best >= 0) begin m_req = 1'b1; m_src = best; end
        end else if (ack_hit || !new_ie) begin
            m_req = 1'b0;
        end
        if (eret_v && m_epc.size() > 0) begin
            void'(m_epc.pop_back());
            void'(m_ssrc.pop_back());
        end
        if (ack_hit) begin
            m_epc.push_back(epc_v);
            m_ssrc.push_back(acked);
            m_pend[acked] = 1'b0;
        end
        m_pend = m_pend | rise;
        m_prev = irq_v;
        m_ie   = new_ie;
    endtask

    function automatic exp_t snap();
        exp_t x;
        x.req  = m_req;
        x.src  = m_src;
        x.vec  = vec_of(m_src);
        x.ie   = m_ie;
        x.dep  = m_epc.size();
        x.epc  = (m_epc.size() == 0) ? 32'h0 : m_epc[$];
        x.pend = m_pend;
        x.svc  = '0;
        foreach (m_ssrc[k]) x.svc[m_ssrc[k]] = 1'b1;
        x.err  = m_err;
        return x;
    endfunction

    // Drive one cycle of inputs, record its expected outcome, move to the next falling edge
    task automatic step(input bit r, input bit [3:0] irq_v, input bit ack_v,
                        input logic [31:0] epc_v, input bit eret_v,
                        input bit we, input bit wd);
        rst = r; irq = irq_v; int_ack = ack_v; epc_in = epc_v; eret = eret_v;
        ie_wr_en = we; ie_wr_data = wd;
        model_step(r, irq_v, ack_v, epc_v, eret_v, we, wd);
        exp_q.push_back(snap());
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic st(input bit [3:0] irq_v, input bit ack_v, input logic [31:0] epc_v,
                      input bit eret_v);
        step(1'b0, irq_v, ack_v, epc_v, eret_v, 1'b0, 1'b0);
    endtask

    // Monitor: after each rising edge compare the DUT against the oldest expectation
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow got=empty exp=entry t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("int_req",    32'(int_req),    32'(e.req));
                chk("int_src",    32'(int_src),    32'(e.src));
                chk("vector_pc",  vector_pc,       e.vec);
                chk("ie",         32'(ie),         32'(e.ie));
                chk("depth",      32'(depth),      32'(e.dep));
                chk("epc_out",    epc_out,         e.epc);
                chk("pending",    32'(pending),    32'(e.pend));
                chk("in_service", 32'(in_service), 32'(e.svc));
                chk("eret_err",   32'(eret_err),   32'(e.err));
            end
        end
    end

    initial begin
        bit [3:0]    iv;
        bit          r, ak, er, we, wd;
        logic [31:0] ep;

        step(1'b1, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_int_req", 32'(int_req), 32'h0);
        chk("rst_depth",   32'(depth),   32'h0);
        chk("rst_ie",      32'(ie),      32'h1);
        chk("rst_epc_out", epc_out,      32'h0);

        // Single source request and ack
        st(4'h1, 0, 0, 0);
        chk("t1_pending", 32'(pending), 32'h1);
        chk("t1_no_req",  32'(int_req), 32'h0);
        st(4'h1, 0, 0, 0);
        chk("t1_req", 32'(int_req), 32'h1);
        chk("t1_src", 32'(int_src), 32'h0);
        st(4'h1, 1, 32'h100, 0);
        chk("t1_depth", 32'(depth),      32'h1);
        chk("t1_epc",   epc_out,         32'h100);
        chk("t1_svc",   32'(in_service), 32'h1);

        // Higher source preempts, then returns
        st(4'h5, 0, 0, 0);
        st(4'h5, 0, 0, 0);
        chk("t2_req", 32'(int_req), 32'h1);
        chk("t2_src", 32'(int_src), 32'h2);
`ifdef INT_VECTOR_EN
        chk("t2_vector", vector_pc, 32'h4200);
`else
        chk("t2_vector", vector_pc, 32'h4000);
`endif
        st(4'h5, 1, 32'h204, 0);
        chk("t2_depth", 32'(depth), 32'h2);
        chk("t2_epc",   epc_out,    32'h204);
        st(4'h5, 0, 0, 1);
        chk("t2_pop_depth", 32'(depth),      32'h1);
        chk("t2_pop_epc",   epc_out,         32'h100);
        chk("t2_pop_svc",   32'(in_service), 32'h1);

        // Lower source cannot preempt; it is served once the higher one returns
        st(4'h0, 0, 0, 0);
        st(4'h4, 0, 0, 0);
        st(4'h4, 0, 0, 0);
        st(4'h4, 1, 32'h300, 0);
        st(4'h6, 0, 0, 0);
        st(4'h6, 0, 0, 0);
        st(4'h6, 0, 0, 0);
        chk("t3_no_req",  32'(int_req), 32'h0);
        chk("t3_pending", 32'(pending), 32'h2);
        st(4'h6, 0, 0, 1);
        st(4'h6, 0, 0, 0);
        chk("t3_req", 32'(int_req), 32'h1);
        chk("t3_src", 32'(int_src), 32'h1);
        st(4'h6, 1, 32'h400, 0);
        st(4'h6, 0, 0, 1);
        st(4'h6, 0, 0, 1);
        chk("t3_empty", 32'(depth), 32'h0);

        // Eret on an empty stack
        st(4'h6, 0, 0, 1);
        chk("t5_err",   32'(eret_err), 32'h1);
        chk("t5_depth", 32'(depth),    32'h0);
        st(4'h6, 0, 0, 0);
        chk("t5_err_clr", 32'(eret_err), 32'h0);

        // IE cleared while a request is outstanding
        st(4'h0, 0, 0, 0);
        st(4'h8, 0, 0, 0);
        st(4'h8, 0, 0, 0);
        chk("ie_req_before", 32'(int_req), 32'h1);
        step(1'b0, 4'h8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("ie_drop_req", 32'(int_req), 32'h0);
        chk("ie_low",      32'(ie),      32'h0);
        chk("ie_pending",  32'(pending), 32'h8);
        step(1'b0, 4'h8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        st(4'h8, 0, 0, 0);
        st(4'h8, 1, 32'h500, 0);
        st(4'h8, 0, 0, 1);

        // Simultaneous eret and ack at depth 1
        st(4'h9, 0, 0, 0);
        st(4'h9, 0, 0, 0);
        st(4'h9, 1, 32'h600, 0);
        st(4'hB, 0, 0, 0);
        st(4'hB, 0, 0, 0);
        st(4'hB, 1, 32'h700, 1);
        chk("sim_depth", 32'(depth),      32'h1);
        chk("sim_epc",   epc_out,         32'h700);
        chk("sim_svc",   32'(in_service), 32'h2);
        st(4'hB, 0, 0, 1);

        // Full stack blocks a fourth source until a return
        st(4'h0, 0, 0, 0);
        st(4'h1, 0, 0, 0); st(4'h1, 0, 0, 0); st(4'h1, 1, 32'h810, 0);
        st(4'h3, 0, 0, 0); st(4'h3, 0, 0, 0); st(4'h3, 1, 32'h820, 0);
        st(4'h7, 0, 0, 0); st(4'h7, 0, 0, 0); st(4'h7, 1, 32'h830, 0);
        chk("t4_full", 32'(depth), 32'h3);
        st(4'hF, 0, 0, 0); st(4'hF, 0, 0, 0); st(4'hF, 0, 0, 0);
        chk("t4_blocked", 32'(int_req), 32'h0);
        chk("t4_pending", 32'(pending), 32'h8);
        st(4'hF, 0, 0, 1);
        chk("t4_pop_depth", 32'(depth), 32'h2);
        st(4'hF, 0, 0, 0);
        chk("t4_req", 32'(int_req), 32'h1);
        chk("t4_src", 32'(int_src), 32'h3);
        st(4'hF, 1, 32'h840, 0);
        st(4'hF, 0, 0, 1); st(4'hF, 0, 0, 1); st(4'hF, 0, 0, 1);

        // New edge in the ack cycle keeps the pending bit
        st(4'h0, 0, 0, 0);
        st(4'h1, 0, 0, 0);
        st(4'h1, 0, 0, 0);
        st(4'h0, 0, 0, 0);
        st(4'h1, 1, 32'h900, 0);
        chk("edge_ack_pending", 32'(pending), 32'h1);
        st(4'h1, 0, 0, 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            iv = irq;
            for (int b = 0; b < NSRC; b++) if ($urandom_range(0, 5) == 0) iv[b] = ~iv[b];
            r  = ($urandom_range(0, 499) == 0);
            ak = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            er = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 29) == 0);
            wd = ($urandom_range(0, 3) != 0);
            ep = $urandom;
            step(r, iv, ak, ep, er, we, wd);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
